// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_pkg
//  Purpose  : Shared IPv4 transmit constants and FSM state encoding.
//  Contents : IP_HDR_LEN, IP_VER_IHL, PROTO_UDP, tx_state_e, hdr_byte().
//  Revision : 1.0  initial release
// ============================================================================
package eth_pkg;

  localparam int         IP_HDR_LEN = 20;
  localparam logic [7:0] IP_VER_IHL = 8'h45;
  localparam logic [7:0] PROTO_UDP  = 8'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CSUM   = 2'd1,
    ST_HEADER = 2'd2,
    ST_DATA   = 2'd3
  } tx_state_e;

  // Pick header byte idx (0 = first on the wire) out of a 160-bit header
  // that is packed MSB-first.
  function automatic logic [7:0] hdr_byte(input logic [159:0] hdr,
                                          input logic [4:0]   idx);
    return 8'(hdr >> (8 * (IP_HDR_LEN - 1 - int'(idx))));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_ip_if.sv
`default_nettype none
// ============================================================================
//  Module   : tx_ip_if
//  Purpose  : 8-bit AXI-Stream byte channel with first/last markers.
//  Signals  : tdata[7:0], tvalid, tready, tlast, tuser (first byte).
//  Modports : master (drives data, receives tready), slave (the reverse).
//  Revision : 1.0  initial release
// ============================================================================
interface tx_ip_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser,
                  input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser,
                  output tready);
endinterface
`default_nettype wire

// File: rtl/ip_csum.sv
`default_nettype none
// ============================================================================
//  Module   : ip_csum
//  Purpose  : IPv4 header checksum over ten 16-bit words (combinational).
//             Usable for generation (checksum word = 0) or for checking a
//             received header (result 0 means a valid header).
//  Ports    : words_i[9:0][15:0] header words, csum_o[15:0] checksum.
//  Revision : 1.0  initial release
// ============================================================================
module ip_csum (
  input  wire logic [9:0][15:0] words_i,
  output logic      [15:0]      csum_o
);

  logic [19:0] sum_d;
  logic [16:0] fold1_d;
  logic [15:0] fold2_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 10; i++) begin
      sum_d = sum_d + 20'(words_i[i]);
    end
    // Two end-around folds: the first may itself carry, the second cannot.
    fold1_d = {1'b0, sum_d[15:0]} + {13'd0, sum_d[19:16]};
    fold2_d = fold1_d[15:0] + {15'd0, fold1_d[16]};
    csum_o  = ~fold2_d;
  end

endmodule
`default_nettype wire

// File: rtl/tx_ip.sv
`default_nettype none
// ============================================================================
//  Module   : tx_ip
//  Purpose  : Prepends a 20-byte IPv4 header to an AXI-Stream byte payload,
//             or bypasses the stream untouched when ip_enable = 0.
//  Ports    : s_axis_aclk / s_axis_areset (sync, active-high), ip_enable,
//             IP_SrcAddr, IP_DestAddr, IP_Protocol, IP_PayloadLen,
//             s_axis_* payload in, m_axis_* packet out, tx_busy.
//  Params   : IP_TTL (default 64), IP_FLAGS_FRAG (default 16'h4000, DF).
//  Macro    : TX_IP_ID_INC_EN - ID field counts packets instead of being 0.
//  Revision : 1.0  initial release
// ============================================================================
module tx_ip
  import eth_pkg::*;
#(
  parameter logic [7:0]  IP_TTL        = 8'd64,
  parameter logic [15:0] IP_FLAGS_FRAG = 16'h4000
) (
  input  wire logic        s_axis_aclk,
  input  wire logic        s_axis_areset,
  input  wire logic        ip_enable,
  input  wire logic [31:0] IP_SrcAddr,
  input  wire logic [31:0] IP_DestAddr,
  input  wire logic [7:0]  IP_Protocol,
  input  wire logic [15:0] IP_PayloadLen,
  input  wire logic [7:0]  s_axis_tdata,
  input  wire logic        s_axis_tvalid,
  output logic             s_axis_tready,
  input  wire logic        s_axis_tlast,
  input  wire logic        s_axis_tuser,
  output logic      [7:0]  m_axis_tdata,
  output logic             m_axis_tvalid,
  input  wire logic        m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             tx_busy
);

  tx_state_e   state_q;
  logic [4:0]  byte_cnt_q;
  logic [15:0] csum_q;
  logic [15:0] totlen_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [7:0]  proto_q;
  logic [15:0] id_d;
  logic [15:0] csum_d;
  logic [159:0] hdr_d;

`ifdef TX_IP_ID_INC_EN
  logic [15:0] id_q;
  assign id_d = id_q;
`else
  assign id_d = 16'h0000;
`endif

  // Header assembled from latched fields; checksum word is zero when fed to
  // the checksum unit and the registered result when emitted.
  ip_csum u_csum (
    .words_i ({{IP_VER_IHL, 8'h00}, totlen_q, id_d, IP_FLAGS_FRAG,
               {IP_TTL, proto_q}, 16'h0000,
               src_q[31:16], src_q[15:0], dst_q[31:16], dst_q[15:0]}),
    .csum_o  (csum_d)
  );

  assign hdr_d = {IP_VER_IHL, 8'h00, totlen_q, id_d, IP_FLAGS_FRAG,
                  IP_TTL, proto_q, csum_q, src_q, dst_q};

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      totlen_q   <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      proto_q    <= '0;
`ifdef TX_IP_ID_INC_EN
      id_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ip_enable && s_axis_tvalid && s_axis_tuser) begin
            src_q      <= IP_SrcAddr;
            dst_q      <= IP_DestAddr;
            proto_q    <= IP_Protocol;
            totlen_q   <= IP_PayloadLen + 16'(IP_HDR_LEN);
            byte_cnt_q <= '0;
            state_q    <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          csum_q  <= csum_d;
          state_q <= ST_HEADER;
        end
        ST_HEADER: begin
          if (m_axis_tready) begin
            if (byte_cnt_q == 5'(IP_HDR_LEN - 1)) begin
              byte_cnt_q <= '0;
              state_q    <= ST_DATA;
            end else begin
              byte_cnt_q <= byte_cnt_q + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
            state_q <= ST_IDLE;
`ifdef TX_IP_ID_INC_EN
            id_q    <= id_q + 16'd1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bypass in IDLE and payload in DATA are pure wires so they add no latency.
  // While reset is held, a non-idle state is silenced immediately.
  always_comb begin
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ip_enable) begin
          m_axis_tdata  = s_axis_tdata;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tlast  = s_axis_tlast;
          m_axis_tuser  = s_axis_tuser;
          s_axis_tready = m_axis_tready;
        end
      end
      ST_HEADER: begin
        if (!s_axis_areset) begin
          m_axis_tdata  = hdr_byte(hdr_d, byte_cnt_q);
          m_axis_tvalid = 1'b1;
          m_axis_tuser  = (byte_cnt_q == 5'd0);
        end
      end
      ST_DATA: begin
        if (!s_axis_areset) begin
          m_axis_tdata  = s_axis_tdata;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tlast  = s_axis_tlast;
          s_axis_tready = m_axis_tready;
        end
      end
      default: ;
    endcase
  end

  assign tx_busy = (state_q != ST_IDLE) && !s_axis_areset;

endmodule
`default_nettype wire
